ext_bus_ctrl: RTL and testbench

Parametrised external-memory bus master for the multiplexed address/data pad bus, the next generation of the fixed 16-bit core bus. Takes one core request (a multi-beat word), latches the address in two phases via le_lo/le_hi, and runs BEATS data beats. It adds programmable wait states, byte-lane write strobes, incrementing beat addresses with high-half re-latch only on carry, and selectable WEb clock-phase gating. Sits between the core's memory port and the io pads.

---
 rtl/ext_bus_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ext_bus_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_ctrl.sv
// Multiplexed address/data pad-bus master. It latches the address in two phases and runs
// BEATS data beats with wait states, byte-lane write strobes and optional WEb clock gating.
//
// state | meaning
// IDLE  | ready, waiting for a core request
// ALO   | drive low address half, pulse le_lo
// AHI   | drive high address half, pulse le_hi (beat 0 or low-half carry)
// DATA  | data phase, cfg_wait+1 cycles
// REC   | strobe recovery / read turnaround
// DONE  | one-cycle completion pulse
module ext_bus_ctrl #(
  parameter int BUS_W  = 16,
  parameter int BEATS  = 2,
  parameter int WAIT_W = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [2*BUS_W-1:0]           req_addr,
  input  logic [BEATS*BUS_W-1:0]       req_wdata,
  input  logic [BEATS*(BUS_W/8)-1:0]   req_be,
  output logic                         rsp_valid,
  output logic [BEATS*BUS_W-1:0]       rsp_rdata,
  input  logic [WAIT_W-1:0]            cfg_wait,
  input  logic [1:0]                   cfg_we_mode,
  output logic [BUS_W-1:0]             bus_out,
  input  logic [BUS_W-1:0]             bus_in,
  output logic                         bus_dir,
  output logic                         le_lo,
  output logic                         le_hi,
  output logic                         OEb,
  output logic [BUS_W/8-1:0]           WEb
);
  localparam int NB     = BUS_W / 8;
  localparam int AW     = 2 * BUS_W;
  localparam int DW     = BEATS * BUS_W;
  localparam int BW     = BEATS * NB;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ALO, S_AHI, S_DATA, S_REC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        mode_q, mode_d;
  logic [WAIT_W-1:0] wait_q, wait_d, cnt_q, cnt_d;
  logic [DW-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BW-1:0]     be_q, be_d;
  logic [AW-1:0]     baddr_q, baddr_d, baddr_inc;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              carry_q, carry_d;
  logic [BUS_W-1:0]  wdata_beat;
  logic [NB-1:0]     be_beat, web_lvl, web_gated;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      mode_q  <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      baddr_q <= '0;
      beat_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      baddr_q <= baddr_d;
      beat_q  <= beat_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    mode_d  = mode_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    baddr_d = baddr_q;
    beat_d  = beat_q;
    carry_d = carry_q;

    req_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_out   = '0;
    bus_dir   = 1'b0;
    le_lo     = 1'b0;
    le_hi     = 1'b0;
    OEb       = 1'b1;
    WEb       = '1;

    wdata_beat = wdata_q[int'(beat_q)*BUS_W +: BUS_W];
    be_beat    = be_q[int'(beat_q)*NB +: NB];
    baddr_inc  = baddr_q + AW'(NB);
    web_lvl    = ~be_beat;
    // Only the strobe timing is gated by the clock phase; lanes with be=0 stay high.
    case (mode_q)
      2'b01:   web_gated = web_lvl | {NB{wb_clk_i}};
      2'b10:   web_gated = web_lvl | {NB{~wb_clk_i}};
      default: web_gated = web_lvl;
    endcase

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          baddr_d = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          wait_d  = cfg_wait;
          mode_d  = cfg_we_mode;
          beat_d  = '0;
          state_d = S_ALO;
        end
      end
      S_ALO: begin
        bus_dir = 1'b1;
        bus_out = baddr_q[BUS_W-1:0];
        le_lo   = 1'b1;
        cnt_d   = wait_q;
        state_d = (beat_q == '0 || carry_q) ? S_AHI : S_DATA;
      end
      S_AHI: begin
        bus_dir = 1'b1;
        bus_out = baddr_q[AW-1:BUS_W];
        le_hi   = 1'b1;
        cnt_d   = wait_q;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (we_q) begin
          bus_dir = 1'b1;
          bus_out = wdata_beat;
          WEb     = web_gated;
        end else begin
          OEb = 1'b0;
        end
        if (cnt_q == '0) begin
          if (!we_q) rdata_d[int'(beat_q)*BUS_W +: BUS_W] = bus_in;
          state_d = S_REC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REC: begin
        if (we_q) begin
          bus_dir = 1'b1;
          bus_out = wdata_beat;
        end
        if (beat_q == LAST_BEAT) begin
          state_d = S_DONE;
        end else begin
          beat_d  = beat_q + 1'b1;
          baddr_d = baddr_inc;
          carry_d = baddr_inc[BUS_W-1:0] < baddr_q[BUS_W-1:0];
          state_d = S_ALO;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Bench for ext_bus_ctrl: directed and random transactions compared cycle by cycle
// against a bus-cycle trace built from the address/beat/wait rules.
module tb_ext_bus_ctrl;
  localparam int BUS_W  = 16;
  localparam int BEATS  = 2;
  localparam int WAIT_W = 4;
  localparam int NB     = BUS_W / 8;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       req_valid = 1'b0;
  logic                       req_ready;
  logic                       req_we = 1'b0;
  logic [2*BUS_W-1:0]         req_addr = '0;
  logic [BEATS*BUS_W-1:0]     req_wdata = '0;
  logic [BEATS*NB-1:0]        req_be = '0;
  logic                       rsp_valid;
  logic [BEATS*BUS_W-1:0]     rsp_rdata;
  logic [WAIT_W-1:0]          cfg_wait = '0;
  logic [1:0]                 cfg_we_mode = '0;
  logic [BUS_W-1:0]           bus_out;
  logic [BUS_W-1:0]           bus_in = '0;
  logic                       bus_dir, le_lo, le_hi, OEb;
  logic [NB-1:0]              WEb;

  always #5 clk = ~clk;

  ext_bus_ctrl #(.BUS_W(BUS_W), .BEATS(BEATS), .WAIT_W(WAIT_W)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cfg_wait(cfg_wait), .cfg_we_mode(cfg_we_mode),
    .bus_out(bus_out), .bus_in(bus_in), .bus_dir(bus_dir),
    .le_lo(le_lo), .le_hi(le_hi), .OEb(OEb), .WEb(WEb)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One expected bus cycle
  typedef struct {
    bit            le_lo, le_hi, dir, chk_out, oeb, wr_data, rd_data, rsp;
    logic [15:0]   out;
    logic [NB-1:0] lvl;
    int            beat;
  } cyc_t;

  cyc_t        trace[$];
  logic [31:0] model_rdata = '0;

  function automatic cyc_t blank();
    cyc_t c;
    c.le_lo = 0; c.le_hi = 0; c.dir = 0; c.chk_out = 0; c.oeb = 1;
    c.wr_data = 0; c.rd_data = 0; c.rsp = 0; c.out = '0; c.lvl = '1; c.beat = 0;
    return c;
  endfunction

  function automatic void build(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int wt);
    logic [31:0] a, prev;
    logic [15:0] wd;
    cyc_t c;
    trace.delete();
    prev = '0;
    for (int k = 0; k < BEATS; k++) begin
      a  = addr + 32'(k * NB);
      wd = wdata[k*16 +: 16];
      c = blank(); c.le_lo = 1; c.dir = 1; c.chk_out = 1; c.out = a[15:0]; trace.push_back(c);
      if (k == 0 || a[15:0] < prev[15:0]) begin
        c = blank(); c.le_hi = 1; c.dir = 1; c.chk_out = 1; c.out = a[31:16]; trace.push_back(c);
      end
      for (int w = 0; w <= wt; w++) begin
        c = blank(); c.beat = k;
        if (we) begin
          c.dir = 1; c.chk_out = 1; c.out = wd; c.wr_data = 1; c.lvl = ~be[k*NB +: NB];
        end else begin
          c.oeb = 0; c.rd_data = 1;
        end
        trace.push_back(c);
      end
      c = blank(); c.beat = k;
      if (we) begin c.dir = 1; c.chk_out = 1; c.out = wd; end
      trace.push_back(c);
      prev = a;
    end
    c = blank(); c.rsp = 1; trace.push_back(c);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rsp"}, rsp_valid, 0);
    chk({tag, "_dir"}, bus_dir, 0);
    chk({tag, "_le"}, {le_hi, le_lo}, 0);
    chk({tag, "_oeb"}, OEb, 1);
    chk({tag, "_web"}, WEb, 2'b11);
  endtask

  // Entered just after a negedge with the DUT in IDLE; returns on the edge leaving DONE.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int wt, input logic [1:0] mode,
                         input logic [31:0] rdv, input bit keep);
    logic [31:0]   exp_rd;
    logic [NB-1:0] lvl, exp_hi, exp_lo;
    cyc_t          c;
    build(we, addr, wdata, be, wt);
    exp_rd = we ? model_rdata : rdv;
    chk("accept_ready", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    cfg_wait = WAIT_W'(wt); cfg_we_mode = mode;
    @(posedge clk);
    for (int i = 0; i < trace.size(); i++) begin
      c = trace[i];
      lvl    = c.wr_data ? c.lvl : 2'b11;
      exp_hi = (mode == 2'b01) ? 2'b11 : lvl;
      exp_lo = (mode == 2'b10) ? 2'b11 : lvl;
      #1;
      chk($sformatf("web_clkhi[%0d]", i), WEb, exp_hi);
      if (i == 0 && !keep) req_valid = 0;
      @(negedge clk); #1;
      chk($sformatf("le_lo[%0d]", i), le_lo, c.le_lo);
      chk($sformatf("le_hi[%0d]", i), le_hi, c.le_hi);
      chk($sformatf("bus_dir[%0d]", i), bus_dir, c.dir);
      chk($sformatf("oeb[%0d]", i), OEb, c.oeb);
      chk($sformatf("web_clklo[%0d]", i), WEb, exp_lo);
      chk($sformatf("rsp_valid[%0d]", i), rsp_valid, c.rsp);
      chk($sformatf("req_ready[%0d]", i), req_ready, 0);
      if (c.chk_out) chk($sformatf("bus_out[%0d]", i), bus_out, c.out);
      if (c.rsp) chk("rsp_rdata", rsp_rdata, exp_rd);
      bus_in = c.rd_data ? rdv[c.beat*16 +: 16] : 16'($urandom);
      cfg_wait = WAIT_W'($urandom); cfg_we_mode = 2'($urandom);
      req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      @(posedge clk);
    end
    model_rdata = exp_rd;
  endtask

  task automatic reset_mid_write();
    req_valid = 1; req_we = 1; req_addr = 32'h0000_4000; req_wdata = 32'h1111_2222;
    req_be = 4'hF; cfg_wait = 4'd5; cfg_we_mode = 2'b00;
    @(posedge clk); #1; req_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid_in_data_web", WEb, 2'b00);
    rst = 1;
    @(posedge clk); #1;
    chk("rstmid_web", WEb, 2'b11);
    chk("rstmid_dir", bus_dir, 0);
    @(negedge clk); #1;
    chk("rstmid_rdata", rsp_rdata, 0);
    chk("rstmid_out", bus_out, 0);
    rst = 0;
    model_rdata = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      chk("rstmid_norsp", rsp_valid, 0);
    end
    chk_idle("rstmid_idle");
  endtask

  initial begin
    bit          keep, we;
    logic [31:0] addr;
    logic [15:0] lo;
    int          gap;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_out", bus_out, 0);
    chk("rst_dir", bus_dir, 0);
    chk("rst_le", {le_hi, le_lo}, 0);
    chk("rst_oeb", OEb, 1);
    chk("rst_web", WEb, 2'b11);
    rst = 0;
    @(negedge clk); #1;
    chk_idle("post_rst");

    run_txn(1, 32'h0000_1000, 32'hBEEF_CAFE, 4'b1111, 0, 2'b00, 32'h0, 0);
    @(negedge clk); #1; chk_idle("idle1");
    run_txn(0, 32'h0001_FFFE, 32'h0, 4'b0000, 3, 2'b00, 32'h5678_1234, 0);
    chk("rd_example", model_rdata, 32'h5678_1234);
    @(negedge clk); #1; chk_idle("idle2");
    run_txn(1, 32'h0000_2000, 32'hA5A5_5A5A, 4'b0110, 1, 2'b01, 32'h0, 0);
    @(negedge clk); #1; chk_idle("idle3");
    run_txn(1, 32'h0000_2100, 32'h0F0F_F0F0, 4'b1001, 2, 2'b10, 32'h0, 0);
    @(negedge clk); #1; chk_idle("idle4");

    reset_mid_write();
    run_txn(0, 32'h0000_0100, 32'h0, 4'h0, 0, 2'b00, 32'hCAFE_F00D, 0);
    @(negedge clk); #1; chk_idle("idle5");

    run_txn(1, 32'h1234_FFFF, 32'h1357_2468, 4'hF, 2, 2'b11, 32'h0, 1);
    @(negedge clk); #1; chk_idle("b2b_idle");
    run_txn(0, 32'h0000_0010, 32'h0, 4'h0, 1, 2'b00, 32'h9ABC_DEF0, 0);
    @(negedge clk); #1; chk_idle("idle6");

    for (int n = 0; n < 40; n++) begin
      keep = ($urandom_range(0, 3) == 0);
      we   = 1'($urandom);
      lo   = 16'($urandom);
      case ($urandom_range(0, 3))
        1: lo = 16'hFFFE;
        2: lo = 16'hFFFF;
        3: lo = 16'hFFFD;
        default: ;
      endcase
      addr = {16'($urandom), lo};
      run_txn(we, addr, $urandom, 4'($urandom), $urandom_range(0, 15), 2'($urandom),
              $urandom, keep);
      @(negedge clk); #1;
      chk_idle("rand_idle");
      if (!keep) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(negedge clk); #1; end
      end
    end
    req_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
